// File: rtl/ball_motion.sv
// Ball position and game-state controller: steps the ball at a fixed tick rate
// from the collision stage's direction code, and handles misses, lives and game over.
module ball_motion #(
  parameter int STEP_DIV   = 416666,
  parameter int SPEED      = 2,
  parameter int START_X    = 320,
  parameter int START_Y    = 240,
  parameter int LIVES      = 3,
  parameter int HOLD_STEPS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] dir_state,
  output logic [9:0] ball_pixel_x,
  output logic [9:0] ball_pixel_y,
  output logic [1:0] lives_left,
  output logic       in_play,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

  localparam int CW = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);
  localparam int HW = $clog2(HOLD_STEPS + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [9:0]    SX        = 10'(START_X);
  localparam logic [9:0]    SY        = 10'(START_Y);
  localparam logic [1:0]    LV        = 2'(LIVES);
  localparam logic signed [10:0] SPD   = 11'(SPEED);
  localparam logic signed [10:0] X_MIN = 11'sd10;
  localparam logic signed [10:0] X_MAX = 11'sd630;
  localparam logic signed [10:0] Y_MIN = 11'sd10;
  localparam logic signed [10:0] Y_MAX = 11'sd470;
  localparam logic [3:0]    DIR_MISS  = 4'd9;

  state_t               state;
  logic [CW-1:0]        step_cnt;
  logic [HW-1:0]        hold_cnt;
  logic                 tick;
  logic signed [10:0]   dx, dy;
  logic [9:0]           next_x, next_y;

  function automatic logic [9:0] sat(input logic signed [10:0] v,
                                     input logic signed [10:0] lo,
                                     input logic signed [10:0] hi);
    if (v < lo)      return lo[9:0];
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  assign tick = (step_cnt == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dx = '0;
    dy = '0;
    case (dir_state)
      4'd0:       dy = SPD;
      4'd1, 4'd8: begin dx = -SPD; dy = -SPD; end
      4'd2, 4'd3: begin dx =  SPD; dy = -SPD; end
      4'd4, 4'd5: begin dx =  SPD; dy =  SPD; end
      4'd6, 4'd7: begin dx = -SPD; dy =  SPD; end
      default:    ;
    endcase
  end

  // Position is carried as 11-bit signed so a step past an edge clamps instead of wrapping.
  assign next_x = sat($signed({1'b0, ball_pixel_x}) + dx, X_MIN, X_MAX);
  assign next_y = sat($signed({1'b0, ball_pixel_y}) + dy, Y_MIN, Y_MAX);

  // NOTE: sequential state uses non-blocking assignments only; later writes in the
  // same block override the counter default below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step_cnt     <= '0;
      hold_cnt     <= '0;
      ball_pixel_x <= SX;
      ball_pixel_y <= SY;
      lives_left   <= LV;
      in_play      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + CW'(1);
      case (state)
        IDLE: begin
          step_cnt     <= '0;
          ball_pixel_x <= SX;
          ball_pixel_y <= SY;
          lives_left   <= LV;
          if (start) begin
            state   <= PLAY;
            in_play <= 1'b1;
          end
        end
        PLAY: begin
          // A miss takes priority over a coincident step tick.
          if (dir_state == DIR_MISS) begin
            lives_left   <= lives_left - 2'd1;
            ball_pixel_x <= SX;
            ball_pixel_y <= SY;
            step_cnt     <= '0;
            hold_cnt     <= '0;
            in_play      <= 1'b0;
            if (lives_left == 2'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end else if (tick) begin
            ball_pixel_x <= next_x;
            ball_pixel_y <= next_y;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= PLAY;
              in_play  <= 1'b1;
              step_cnt <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        OVER: begin
          step_cnt     <= '0;
          ball_pixel_x <= SX;
          ball_pixel_y <= SY;
          lives_left   <= 2'd0;
          if (start) begin
            state      <= PLAY;
            lives_left <= LV;
            in_play    <= 1'b1;
            game_over  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a short step period (STEP_DIV=4, SPEED=2,
// HOLD_STEPS=2, LIVES=3); outputs are sampled 1 ns after each rising edge.
module tb_ball_motion;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dir_state = 4'd10;
  logic [9:0] ball_pixel_x, ball_pixel_y;
  logic [1:0] lives_left;
  logic       in_play, game_over;

  int passed = 0;
  int total  = 0;

  ball_motion #(
    .STEP_DIV(4), .SPEED(2), .START_X(320), .START_Y(240), .LIVES(3), .HOLD_STEPS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir_state(dir_state),
    .ball_pixel_x(ball_pixel_x), .ball_pixel_y(ball_pixel_y),
    .lives_left(lives_left), .in_play(in_play), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] obs();
    return {ball_pixel_x, ball_pixel_y, lives_left, in_play, game_over};
  endfunction

  function automatic logic [23:0] pk(int x, int y, int l, bit ip, bit go);
    return {10'(x), 10'(y), 2'(l), ip, go};
  endfunction

  function automatic string fmt(logic [23:0] v);
    return $sformatf("x=%0d y=%0d lives=%0d in_play=%0b game_over=%0b",
                     v[23:14], v[13:4], v[3:2], v[1], v[0]);
  endfunction

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_step(logic [3:0] d);
    dir_state = d;
    edges(STEP);
  endtask

  // Reset, then a start pulse; returns 1 ns after the PLAY entry edge.
  task automatic start_game(logic [3:0] d);
    @(posedge clk); #1;
    reset_n = 1'b0; #2; reset_n = 1'b1;
    dir_state = d;
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    reset_n = 1'b0; dir_state = 4'd9;
    #3;
    exp = pk(320, 240, 3, 0, 0);
    total++;
    if (obs() !== exp) $display("FAIL reset_async: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    edges(3);
    total++;
    if (obs() !== exp) $display("FAIL idle_ignores_dir: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
  endtask

  task automatic test_move_down();
    logic [23:0] exp;
    start_game(4'd0);
    exp = pk(320, 240, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL play_entry: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    for (int e = 1; e <= 8; e++) begin
      edges(1);
      exp = pk(320, 240 + 2 * (e / 4), 3, 1, 0);
      total++;
      if (obs() !== exp)
        $display("FAIL move_down_edge%0d: got %s, expected %s", e, fmt(obs()), fmt(exp));
      else passed++;
    end
  endtask

  task automatic test_saturate();
    logic [23:0] exp;
    start_game(4'd10);
    for (int i = 0; i < 70; i++) do_step(4'd1);
    for (int i = 0; i < 42; i++) begin
      do_step(4'd6);
      do_step(4'd1);
    end
    exp = pk(12, 100, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL reach_12_100: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    for (int s = 1; s <= 3; s++) begin
      do_step(4'd1);
      exp = pk(10, 100 - 2 * s, 3, 1, 0);
      total++;
      if (obs() !== exp)
        $display("FAIL sat_x_step%0d: got %s, expected %s", s, fmt(obs()), fmt(exp));
      else passed++;
    end
    for (int i = 0; i < 42; i++) do_step(4'd1);
    exp = pk(10, 10, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL reach_10_10: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    do_step(4'd1);
    total++;
    if (obs() !== exp) $display("FAIL sat_xy_corner: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
  endtask

  task automatic test_miss_and_over();
    logic [23:0] exp;
    start_game(4'd10);
    for (int i = 0; i < 40; i++) do_step(4'd4);
    for (int i = 0; i < 70; i++) do_step(4'd0);
    exp = pk(400, 460, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL reach_400_460: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    dir_state = 4'd9;
    edges(1);
    exp = pk(320, 240, 2, 0, 0);
    total++;
    if (obs() !== exp) $display("FAIL miss_reload: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    // dir 9 held and a start pulse issued while in HOLD: both must be ignored.
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      edges(1);
    end
    start = 1'b0;
    total++;
    if (obs() !== exp) $display("FAIL hold_frozen: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    dir_state = 4'd10;
    edges(1);
    exp = pk(320, 240, 2, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL hold_exit: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;

    dir_state = 4'd9;
    edges(1);
    dir_state = 4'd10;
    exp = pk(320, 240, 1, 0, 0);
    total++;
    if (obs() !== exp) $display("FAIL second_miss: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    edges(8);
    exp = pk(320, 240, 1, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL second_resume: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    dir_state = 4'd9;
    edges(1);
    exp = pk(320, 240, 0, 0, 1);
    total++;
    if (obs() !== exp) $display("FAIL third_miss_over: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    dir_state = 4'd0;
    edges(5);
    total++;
    if (obs() !== exp) $display("FAIL over_parked: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    start = 1'b1;
    edges(1);
    start = 1'b0;
    exp = pk(320, 240, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL restart: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    edges(4);
    exp = pk(320, 242, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL restart_move: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
  endtask

  task automatic test_miss_on_tick();
    logic [23:0] exp;
    start_game(4'd0);
    edges(4);
    exp = pk(320, 242, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL pre_tick_move: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    edges(3);
    dir_state = 4'd9;
    edges(1);
    dir_state = 4'd10;
    exp = pk(320, 240, 2, 0, 0);
    total++;
    if (obs() !== exp) $display("FAIL miss_on_tick: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
  endtask

  task automatic test_async_reset_mid_play();
    logic [23:0] exp;
    start_game(4'd4);
    do_step(4'd4);
    do_step(4'd4);
    exp = pk(324, 244, 3, 1, 0);
    total++;
    if (obs() !== exp) $display("FAIL pre_reset: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    exp = pk(320, 240, 3, 0, 0);
    total++;
    if (obs() !== exp) $display("FAIL reset_mid_play: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
    edges(1);
    reset_n = 1'b1;
    dir_state = 4'd0;
    edges(3);
    total++;
    if (obs() !== exp) $display("FAIL reset_exit_idle: got %s, expected %s", fmt(obs()), fmt(exp));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_move_down();
    test_saturate();
    test_miss_and_over();
    test_miss_on_tick();
    test_async_reset_mid_play();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter STEP_DIV, default 416666; clk cycles per motion step (60 Hz at 25 MHz); legal range 2..2^20.
REQ-002 Parameter SPEED, default 2; pixels moved per axis per step; legal range 1..8.
REQ-003 Parameter START_X, default 320, and START_Y, default 240; serve/park position of the ball centre.
REQ-004 Parameter LIVES, default 3; misses allowed per game; legal range 1..3.
REQ-005 Parameter HOLD_STEPS, default 60; steps the ball is frozen after a miss before play resumes.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a game; honoured only in IDLE or OVER.
REQ-009 dir_state  input  4  registered direction/collision code from the collision stage.
REQ-010 ball_pixel_x  output  10  ball centre x, registered.
REQ-011 ball_pixel_y  output  10  ball centre y, registered.
REQ-012 lives_left  output  2  remaining lives, registered.
REQ-013 in_play  output  1  high only in PLAY.
REQ-014 game_over  output  1  high only in OVER.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY, HOLD and OVER.
REQ-016 Direction decode (dx,dy) SHALL be: 0=(0,+1); 1=(-1,-1); 2=(+1,-1); 3=(+1,-1); 4=(+1,+1); 5=(+1,+1); 6=(-1,+1); 7=(-1,+1); 8=(-1,-1); 9 and 10..15=(0,0). +y is down.
REQ-017 A step counter SHALL count 0..STEP_DIV-1 and wrap; it SHALL be cleared on every entry to PLAY or HOLD.
REQ-018 In PLAY, on each edge where the counter equals STEP_DIV-1, position SHALL update by (dx*SPEED, dy*SPEED); first move occurs STEP_DIV edges after PLAY entry.
REQ-019 Arithmetic SHALL be 11-bit signed, then saturated: x to [10,630], y to [10,470]; no wrap-around.
REQ-020 IDLE: ball held at (START_X,START_Y), lives_left=LIVES; start -> PLAY on the next edge.
REQ-021 PLAY: dir_state==9 sampled on any edge (independent of step counter) SHALL decrement lives_left and load (START_X,START_Y) on that same edge.
REQ-022 After the decrement, lives_left>0 -> HOLD; lives_left==0 -> OVER.
REQ-023 A miss and a step tick on the same edge: the miss wins; no move is applied.
REQ-024 HOLD: position frozen; dir_state ignored (including 9); after HOLD_STEPS full step periods -> PLAY.
REQ-025 OVER: ball parked at start, lives_left=0, game_over=1; start -> PLAY with lives_left reloaded to LIVES and ball at start.
REQ-026 start SHALL be ignored in PLAY and HOLD.
REQ-027 Only one miss SHALL be counted per PLAY visit, since PLAY is left on the miss edge.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, counter=0, ball_pixel_x=START_X, ball_pixel_y=START_Y, lives_left=LIVES, in_play=0, game_over=0, regardless of current state.
REQ-029 Deassertion SHALL be the only reset exit; the first state change is evaluated on the first rising edge with reset_n high.

Verification (STEP_DIV=4, SPEED=2, HOLD_STEPS=2, LIVES=3)
REQ-030 Reset, start pulse, dir_state=0 -> in_play=1; y=240 until 4 edges after PLAY entry, then 242, 244 every 4 edges; x=320 throughout.
REQ-031 dir_state=1 from (12,100), 3 steps -> (10,98), (10,96), (10,94); x saturates at 10.
REQ-032 dir_state=9 for one cycle in PLAY at (400,460) -> next edge (320,240), lives_left=2, HOLD; dir_state=9 during HOLD -> no change; PLAY resumes 8 edges later.
REQ-033 Three misses -> lives_left=0, game_over=1, ball (320,240); start -> PLAY, lives_left=3, game_over=0.
REQ-034 Miss coincident with step tick -> ball (320,240), no extra displacement; reset_n pulsed low mid-PLAY -> outputs at reset values asynchronously, before the next clock edge.
